// File: rtl/dds_phase_accumulator_if.sv
// Frequency-tuning-word load channel into the DDS phase accumulator.
// Master offers a word with ftw_valid; slave takes it when ftw_ready is high.
interface dds_phase_accumulator_if #(
    parameter int PHASE_W = 32
);
    logic [PHASE_W-1:0] ftw_in;
    logic               ftw_valid;
    logic               ftw_ready;

    modport master (output ftw_in, output ftw_valid, input  ftw_ready);
    modport slave  (input  ftw_in, input  ftw_valid, output ftw_ready);
endinterface

// File: rtl/dds_phase_accumulator.sv
// DDS phase accumulator: advances by a double-buffered FTW on each synchronized
// rising edge of tick_in and emits an offset, truncated LUT phase address.
module dds_phase_accumulator #(
    parameter int PHASE_W     = 32,
    parameter int OUT_W       = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_in,
    input  logic                  rst,
    input  logic                  tick_in,
    input  logic                  enable,
    dds_phase_accumulator_if.slave ftw_if,
    input  logic [PHASE_W-1:0]    phase_offset,
    output logic [OUT_W-1:0]      phase_out,
    output logic                  phase_valid,
    output logic                  wrap
);

    function automatic logic [OUT_W-1:0] f_phase_addr(
        input logic [PHASE_W-1:0] acc,
        input logic [PHASE_W-1:0] offset
    );
        logic [PHASE_W-1:0] s;
        s = acc + offset;
        return s[PHASE_W-1 -: OUT_W];
    endfunction

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_prev;
    logic                   r_step_p0;

    logic [PHASE_W-1:0]     r_acc;
    logic [PHASE_W-1:0]     r_active_ftw;
    logic [PHASE_W-1:0]     r_shadow;
    logic                   r_pending;

    logic [OUT_W-1:0]       r_phase_p1;
    logic                   r_vld_p1;
    logic                   r_wrap_p1;

    logic                   w_step_edge;
    logic                   w_advance;
    logic                   w_xfer;
    logic [PHASE_W-1:0]     w_ftw_eff;
    logic [PHASE_W:0]       w_sum;

    assign w_step_edge = r_sync[SYNC_STAGES-1] & ~r_sync_prev;
    assign w_advance   = r_step_p0 & enable;
    // Shadow only accepts while empty, so a held word is never overwritten.
    assign w_xfer      = ftw_if.ftw_valid & ~r_pending;
    assign w_ftw_eff   = r_pending ? r_shadow : r_active_ftw;
    assign w_sum       = {1'b0, r_acc} + {1'b0, w_ftw_eff};

    assign ftw_if.ftw_ready = ~r_pending;

    // Stage p0: synchronize tick_in and register its rising edge.
    // Edge flop resets low so a tick already high at reset release still counts.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_sync      <= '0;
            r_sync_prev <= 1'b0;
            r_step_p0   <= 1'b0;
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], tick_in};
            r_sync_prev <= r_sync[SYNC_STAGES-1];
            r_step_p0   <= w_step_edge;
        end
    end

    // Shadow/active FTW pair; a same-cycle step consumes the old word first.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_shadow     <= '0;
            r_pending    <= 1'b0;
            r_active_ftw <= '0;
        end else begin
            if (w_advance) begin
                r_active_ftw <= w_ftw_eff;
            end
            if (w_xfer) begin
                r_shadow  <= ftw_if.ftw_in;
                r_pending <= 1'b1;
            end else if (w_advance) begin
                r_pending <= 1'b0;
            end
        end
    end

    // Stage p1: accumulate and produce the phase address with strobes.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_acc      <= '0;
            r_phase_p1 <= '0;
            r_vld_p1   <= 1'b0;
            r_wrap_p1  <= 1'b0;
        end else begin
            r_vld_p1  <= w_advance;
            r_wrap_p1 <= w_advance & w_sum[PHASE_W];
            if (w_advance) begin
                r_acc      <= w_sum[PHASE_W-1:0];
                r_phase_p1 <= f_phase_addr(w_sum[PHASE_W-1:0], phase_offset);
            end
        end
    end

    assign phase_out   = r_phase_p1;
    assign phase_valid = r_vld_p1;
    assign wrap        = r_wrap_p1;

endmodule

// File: tb/tb_dds_phase_accumulator.sv
// Self-checking bench for dds_phase_accumulator: directed scenarios plus random
// ticks/FTWs, checked every cycle against a behavioural phase model.
module tb_dds_phase_accumulator;

    localparam int PW = 32;
    localparam int OW = 12;

    logic          clk_in;
    logic          rst;
    logic          tick_in;
    logic          enable;
    logic [PW-1:0] phase_offset;
    logic [OW-1:0] phase_out;
    logic          phase_valid;
    logic          wrap;

    dds_phase_accumulator_if #(.PHASE_W(PW)) ftw_if ();

    dds_phase_accumulator #(.PHASE_W(PW), .OUT_W(OW), .SYNC_STAGES(2)) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .tick_in     (tick_in),
        .enable      (enable),
        .ftw_if      (ftw_if),
        .phase_offset(phase_offset),
        .phase_out   (phase_out),
        .phase_valid (phase_valid),
        .wrap        (wrap)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural model state
    bit [PW-1:0] m_acc, m_active, m_shadow;
    bit          m_pending, m_prev_tick;
    bit [OW-1:0] e_phase;
    bit          e_valid, e_wrap;
    int          cyc = 0;
    int          xfer_cnt = 0;
    int          due[$];

    // Strobe log as seen on the DUT outputs
    logic [OW-1:0] lg_ph[$];
    logic          lg_wr[$];
    int            lg_cyc[$];

    initial begin
        logic [PW:0]   sum;
        logic [PW-1:0] eff, tmp;
        bit            xfer;
        forever begin
            @(posedge clk_in);
            if (!rst) begin
                m_acc = '0; m_active = '0; m_shadow = '0; m_pending = 1'b0;
                m_prev_tick = 1'b0; e_phase = '0; e_valid = 1'b0; e_wrap = 1'b0;
                due.delete();
            end else begin
                cyc++;
                xfer    = ftw_if.ftw_valid && !m_pending;
                e_valid = 1'b0;
                e_wrap  = 1'b0;
                if (tick_in && !m_prev_tick) due.push_back(cyc + 3);
                m_prev_tick = tick_in;
                if (due.size() > 0 && due[0] == cyc) begin
                    void'(due.pop_front());
                    if (enable) begin
                        eff       = m_pending ? m_shadow : m_active;
                        sum       = {1'b0, m_acc} + {1'b0, eff};
                        e_wrap    = sum[PW];
                        m_acc     = sum[PW-1:0];
                        m_active  = eff;
                        m_pending = 1'b0;
                        tmp       = m_acc + phase_offset;
                        e_phase   = tmp[PW-1 -: OW];
                        e_valid   = 1'b1;
                    end
                end
                if (xfer) begin
                    m_shadow  = ftw_if.ftw_in;
                    m_pending = 1'b1;
                    xfer_cnt++;
                end
            end
            #1;
            check("phase_valid", 64'(phase_valid), 64'(e_valid));
            check("wrap", 64'(wrap), 64'(e_wrap));
            check("phase_out", 64'(phase_out), 64'(e_phase));
            check("ftw_ready", 64'(ftw_if.ftw_ready), 64'(!m_pending));
            if (phase_valid === 1'b1) begin
                lg_ph.push_back(phase_out);
                lg_wr.push_back(wrap);
                lg_cyc.push_back(cyc);
            end
        end
    end

    task automatic clear_log();
        lg_ph.delete(); lg_wr.delete(); lg_cyc.delete();
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst = 1'b0;
        repeat (3) @(negedge clk_in);
        rst = 1'b1;
    endtask

    task automatic do_tick(input int h);
        @(negedge clk_in);
        tick_in = 1'b1;
        repeat (h) @(negedge clk_in);
        tick_in = 1'b0;
        repeat (h - 1) @(negedge clk_in);
    endtask

    task automatic set_ftw(input logic [PW-1:0] w);
        int start;
        @(negedge clk_in);
        ftw_if.ftw_in    = w;
        ftw_if.ftw_valid = 1'b1;
        start = xfer_cnt;
        for (int i = 0; i < 200 && xfer_cnt == start; i++) @(negedge clk_in);
        check("ftw_xfer_timeout", 64'(xfer_cnt != start), 64'd1);
        ftw_if.ftw_valid = 1'b0;
    endtask

    // Returns edge index (1 = edge that first samples tick high) of the strobe.
    task automatic wait_strobe(output int n);
        n = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk_in);
            #1;
            if (phase_valid === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic check_log(input string tag, input int idx, input logic [OW-1:0] ph, input logic wr);
        if (idx < lg_ph.size()) begin
            check({tag, "_ph"}, 64'(lg_ph[idx]), 64'(ph));
            check({tag, "_wr"}, 64'(lg_wr[idx]), 64'(wr));
        end else begin
            check({tag, "_missing"}, 64'(lg_ph.size()), 64'(idx + 1));
        end
    endtask

    initial begin
        int n;
        rst = 1'b0; tick_in = 1'b0; enable = 1'b1; phase_offset = '0;
        ftw_if.ftw_in = '0; ftw_if.ftw_valid = 1'b0;
        repeat (2) @(negedge clk_in);
        check("reset_phase", 64'(phase_out), 64'd0);
        check("reset_valid", 64'(phase_valid), 64'd0);
        check("reset_ready", 64'(ftw_if.ftw_ready), 64'd1);
        rst = 1'b1;

        // 1 MHz ticks, quarter-turn FTW
        set_ftw(32'h4000_0000);
        clear_log();
        repeat (4) do_tick(50);
        check_log("t1_s0", 0, 12'h400, 1'b0);
        check_log("t1_s1", 1, 12'h800, 1'b0);
        check_log("t1_s2", 2, 12'hC00, 1'b0);
        check_log("t1_s3", 3, 12'h000, 1'b1);
        for (int i = 1; i < 4 && i < lg_cyc.size(); i++)
            check("t1_spacing", 64'(lg_cyc[i] - lg_cyc[i-1]), 64'd100);

        // Latency and held-high tick
        do_reset();
        repeat (4) @(negedge clk_in);
        clear_log();
        tick_in = 1'b1;
        wait_strobe(n);
        check("t2_latency_edges", 64'(n), 64'd4);
        repeat (20) @(negedge clk_in);
        check("t2_single_strobe", 64'(lg_ph.size()), 64'd1);
        tick_in = 1'b0;
        repeat (4) @(negedge clk_in);

        // Handshake: pending word, second offer refused
        do_reset();
        set_ftw(32'h1000_0000);
        do_tick(6);
        set_ftw(32'h2000_0000);
        check("t3_ready_lo", 64'(ftw_if.ftw_ready), 64'd0);
        ftw_if.ftw_in = 32'h3000_0000;
        ftw_if.ftw_valid = 1'b1;
        repeat (8) @(negedge clk_in);
        ftw_if.ftw_valid = 1'b0;
        clear_log();
        tick_in = 1'b1;
        wait_strobe(n);
        check("t3_latency", 64'(n), 64'd4);
        check("t3_ready_hi", 64'(ftw_if.ftw_ready), 64'd1);
        repeat (5) @(negedge clk_in);
        tick_in = 1'b0;
        repeat (5) @(negedge clk_in);
        do_tick(6);
        check_log("t3_s0", 0, 12'h300, 1'b0);
        check_log("t3_s1", 1, 12'h500, 1'b0);

        // Transfer coincident with step
        do_reset();
        set_ftw(32'h1000_0000);
        do_tick(6);
        clear_log();
        @(negedge clk_in);
        tick_in = 1'b1;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        ftw_if.ftw_in = 32'h2000_0000;
        ftw_if.ftw_valid = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        ftw_if.ftw_valid = 1'b0;
        check("t4_ready_lo", 64'(ftw_if.ftw_ready), 64'd0);
        repeat (4) @(negedge clk_in);
        tick_in = 1'b0;
        repeat (5) @(negedge clk_in);
        do_tick(6);
        check_log("t4_s0", 0, 12'h200, 1'b0);
        check_log("t4_s1", 1, 12'h400, 1'b0);

        // Enable low freezes everything, pending word kept
        do_reset();
        set_ftw(32'h0800_0000);
        do_tick(6);
        set_ftw(32'h0800_0000);
        clear_log();
        enable = 1'b0;
        repeat (3) do_tick(6);
        check("t5_no_strobe", 64'(lg_ph.size()), 64'd0);
        check("t5_frozen", 64'(phase_out), 64'h080);
        check("t5_pending", 64'(ftw_if.ftw_ready), 64'd0);
        enable = 1'b1;
        do_tick(6);
        check_log("t5_resume", 0, 12'h100, 1'b0);

        // Half-turn offset with zero FTW, then async reset mid-stream
        do_reset();
        phase_offset = 32'h8000_0000;
        set_ftw(32'h0000_0000);
        clear_log();
        repeat (3) do_tick(6);
        for (int i = 0; i < 3; i++) check_log("t6_s", i, 12'h800, 1'b0);
        set_ftw(32'h1234_5678);
        @(negedge clk_in);
        tick_in = 1'b1;
        repeat (2) @(posedge clk_in);
        #2;
        rst = 1'b0;
        #1;
        check("t6_rst_phase", 64'(phase_out), 64'd0);
        check("t6_rst_valid", 64'(phase_valid), 64'd0);
        check("t6_rst_wrap", 64'(wrap), 64'd0);
        check("t6_rst_ready", 64'(ftw_if.ftw_ready), 64'd1);
        repeat (3) @(negedge clk_in);
        tick_in = 1'b0;
        rst = 1'b1;
        phase_offset = '0;
        repeat (4) @(negedge clk_in);

        // Randomized traffic
        for (int it = 0; it < 40; it++) begin
            @(negedge clk_in);
            enable       = ($urandom_range(0, 4) != 0);
            phase_offset = $urandom;
            if (!m_pending && $urandom_range(0, 1) == 1) set_ftw($urandom);
            do_tick(int'($urandom_range(3, 25)));
        end

        repeat (10) @(negedge clk_in);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/dds_phase_accumulator.md
Name: dds_phase_accumulator

Overview:
DDS phase accumulator stage sitting directly downstream of frequency_divider. It runs on the 100 MHz system clock and consumes the divider's clk_out as a sample tick. On each tick it advances a PHASE_W-bit accumulator by a frequency tuning word (FTW) and emits a truncated, offset-adjusted phase address for the waveform LUT stage. The FTW is loaded through a valid/ready handshake and is double-buffered so that frequency changes stay phase-coherent.

Parameters:
PHASE_W, 32, accumulator and FTW width in bits
OUT_W, 12, phase address width; MSBs of the accumulator (OUT_W <= PHASE_W)
SYNC_STAGES, 2, synchronizer flops on tick_in (>= 2)

Ports:
clk_in  input  1  system clock (100 MHz)
rst  input  1  asynchronous active-low reset
tick_in  input  1  sample-rate clock from frequency_divider clk_out; treated as asynchronous
enable  input  1  when low, ticks are ignored and the accumulator holds
ftw_in  input  PHASE_W  frequency tuning word
ftw_valid  input  1  ftw_in is valid
ftw_ready  output  1  shadow register empty; can accept a word
phase_offset  input  PHASE_W  static phase offset added before truncation
phase_out  output  OUT_W  phase address: bits [PHASE_W-1 -: OUT_W] of (acc + phase_offset)
phase_valid  output  1  one-cycle strobe; phase_out updated
wrap  output  1  one-cycle strobe, coincident with phase_valid, on accumulator carry-out

Behaviour:
- Reset (rst=0, asynchronous): acc=0, active_ftw=0, shadow empty, synchronizer and edge-detect flops=0, phase_out=0, phase_valid=0, wrap=0, ftw_ready=1.
- Tick path: tick_in passes through a SYNC_STAGES flop chain. step = sync_last & ~sync_prev, giving one step per tick_in rising edge. If tick_in is already high at reset release, that counts as an edge.
- Latency: phase_valid rises SYNC_STAGES+1 clk_in edges after the first edge that samples tick_in high. For SYNC_STAGES=2, that is edge k+3 when tick_in is first sampled high at edge k.
- On step with enable=1:
  - ftw_eff = shadow if a word is pending, else active_ftw.
  - acc <= (acc + ftw_eff) mod 2^PHASE_W.
  - active_ftw <= ftw_eff, and the shadow is cleared.
  - phase_out <= MSBs of (new acc + phase_offset), mod 2^PHASE_W.
  - phase_valid <= 1 for one cycle.
  - wrap <= carry-out of (acc + ftw_eff). phase_offset does not affect wrap.
- On step with enable=0: no state changes and no strobes. A pending shadow word stays pending.
- FTW handshake:
  - A transfer occurs when ftw_valid & ftw_ready at a clk_in edge. The shadow is loaded and ftw_ready goes low on the next cycle.
  - ftw_ready returns high the cycle after the step that consumes the shadow.
  - ftw_in is ignored while ftw_ready=0. The source must hold it; words are never dropped or overwritten.
  - Transfer and step in the same cycle: the step uses the old pending/active word. The newly transferred word is applied on the following step.
- FTW=0: phase_out stays constant; phase_valid still pulses on every step.
- Reset mid-operation: all state returns to reset values immediately, including any pending shadow word.
- Strobes never last more than 1 cycle. Ticks are assumed to arrive at least SYNC_STAGES+2 cycles apart.

Test Plan:
1. Reset, then FTW=0x4000_0000 loaded, offset=0, tick_in = 1 MHz (divide-by-100 clock) -> phase_out sequence 0x400, 0x800, 0xC00, 0x000. wrap=1 only with 0x000. phase_valid spacing is exactly 100 cycles.
2. tick_in first sampled high at edge k (SYNC_STAGES=2) -> phase_valid=1 at edge k+3 only. A held-high tick_in produces no further strobes.
3. Handshake: FTW=0x1000_0000 active, ftw_valid held with 0x2000_0000 -> ftw_ready=0 after the transfer. The next step advances by 0x2000_0000. ftw_ready=1 one cycle after that step. A second word offered while ready=0 is not taken.
4. ftw_valid transfer in the same cycle as step -> that step uses the old FTW, and the next step uses the new one.
5. enable=0 for 3 ticks with FTW=0x0800_0000 -> phase_out and acc are frozen, no strobes, pending word retained. Re-enable -> resumes from the held value.
6. phase_offset=0x8000_0000, FTW=0 -> phase_out=0x800 on every step, wrap=0. Assert rst mid-stream -> all outputs 0 asynchronously, ftw_ready=1.
